dcache_direct: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache.
- Sits directly downstream of the CPU memory stage and upstream of the data memory.
- Returns hits combinationally in the memory-stage cycle.
- Asserts `stall` to the hazard unit on misses and stores while a memory-side req/ack transaction completes.
- One 32-bit word per line.

---
 rtl/dcache_direct_if.sv | 30 +++
 rtl/dcache_direct.sv | 169 ++++++++++++++++
 tb/tb_dcache_direct.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_direct_if.sv
// CPU-side and memory-side signal bundle of the direct-mapped data cache.
// slave = cache view, master = pipeline/memory environment view.
interface dcache_direct_if #(
   parameter int WIDTH = 32
);
   logic             cpu_re;
   logic             cpu_we;
   logic [2:0]       cpu_mode;
   logic [WIDTH-1:0] cpu_addr;
   logic [WIDTH-1:0] cpu_wdata;
   logic [WIDTH-1:0] cpu_rdata;
   logic             stall;
   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [3:0]       mem_wstrb;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ack;

   modport slave (
      input  cpu_re, cpu_we, cpu_mode, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
      output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output cpu_re, cpu_we, cpu_mode, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
      input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_direct #(
   parameter int WIDTH = 32,
   parameter int LINES = 16
) (
   input  logic             clk,
   input  logic             rst,
   dcache_direct_if.slave   bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count
`endif
);
   localparam int IDX  = $clog2(LINES);
   localparam int TAGW = WIDTH - IDX - 2;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

   state_t           state_q;
   logic [LINES-1:0] valid_q;
   logic [TAGW-1:0]  tag_q  [LINES];
   logic [WIDTH-1:0] data_q [LINES];
   logic             mem_req_q, mem_we_q, done_q;
   logic [WIDTH-1:0] mem_addr_q, mem_wdata_q;
   logic [3:0]       mem_wstrb_q;

   logic [IDX-1:0]   cpu_idx, mem_idx;
   logic [TAGW-1:0]  cpu_tag, mem_tag;
   logic             line_hit, wr_hit, idle, store_new, load_req, load_hit, load_miss;
   logic [WIDTH-1:0] line_word, rdata_ext, st_wdata, merged;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [3:0]       st_wstrb;

   assign cpu_idx = bus.cpu_addr[IDX+1:2];
   assign cpu_tag = bus.cpu_addr[WIDTH-1:IDX+2];
   assign mem_idx = mem_addr_q[IDX+1:2];
   assign mem_tag = mem_addr_q[WIDTH-1:IDX+2];

   assign line_hit  = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
   assign wr_hit    = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);
   assign idle      = rst && (state_q == S_IDLE);
   // done_q marks the cycle right after an ack: the held store retires without reissuing
   assign store_new = idle && bus.cpu_we && !done_q;
   assign load_req  = idle && bus.cpu_re && !bus.cpu_we;
   assign load_hit  = load_req && line_hit;
   assign load_miss = load_req && !line_hit;

   assign bus.stall     = rst && ((state_q != S_IDLE) || store_new || load_miss);
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wstrb = mem_wstrb_q;
   assign bus.cpu_rdata = load_hit ? rdata_ext : '0;

   always_comb begin
      line_word = data_q[cpu_idx];
      ld_byte   = line_word[{bus.cpu_addr[1:0], 3'b000} +: 8];
      ld_half   = bus.cpu_addr[1] ? line_word[31:16] : line_word[15:0];
      case (bus.cpu_mode)
         3'b000:  rdata_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  rdata_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  rdata_ext = {24'h0, ld_byte};
         3'b101:  rdata_ext = {16'h0, ld_half};
         default: rdata_ext = line_word;
      endcase
   end

   always_comb begin
      case (bus.cpu_mode[1:0])
         2'b00: begin
            st_wstrb = 4'b0001 << bus.cpu_addr[1:0];
            st_wdata = {4{bus.cpu_wdata[7:0]}};
         end
         2'b01: begin
            st_wstrb = bus.cpu_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{bus.cpu_wdata[15:0]}};
         end
         default: begin
            st_wstrb = 4'b1111;
            st_wdata = bus.cpu_wdata;
         end
      endcase
   end

   always_comb begin
      merged = data_q[mem_idx];
      for (int b = 0; b < 4; b++) begin
         if (mem_wstrb_q[b]) merged[8*b +: 8] = mem_wdata_q[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst && bus.mem_ack) begin
         if (state_q == S_FILL) begin
            data_q[mem_idx] <= bus.mem_rdata;
            tag_q[mem_idx]  <= mem_tag;
         end else if (state_q == S_WRITE && wr_hit) begin
            data_q[mem_idx] <= merged;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         valid_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= 4'b0000;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (store_new) begin
                  state_q     <= S_WRITE;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= {bus.cpu_addr[WIDTH-1:2], 2'b00};
                  mem_wdata_q <= st_wdata;
                  mem_wstrb_q <= st_wstrb;
               end else if (load_miss) begin
                  state_q     <= S_FILL;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= {bus.cpu_addr[WIDTH-1:2], 2'b00};
                  mem_wdata_q <= '0;
                  mem_wstrb_q <= 4'b0000;
               end
            end
            S_FILL, S_WRITE: begin
               if (bus.mem_ack) begin
                  if (state_q == S_FILL) valid_q[mem_idx] <= 1'b1;
                  state_q     <= S_IDLE;
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_wstrb_q <= 4'b0000;
                  done_q      <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   // the retry that completes a fill is not a hit
   always_ff @(posedge clk) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (load_hit && !done_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
         if (load_miss && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_direct.sv
// Scoreboard bench for dcache_direct: driver queues expected memory transactions
// and load/store completions, a monitor pops and compares them as the DUT presents them.
module tb_dcache_direct;
   localparam int K_MEM = 0;
   localparam int K_LD  = 1;
   localparam int K_ST  = 2;

   typedef struct {
      int          kind;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          stalls;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   ack_lat;
   bit   resp_en;
   bit   man_ack;
   exp_t sbq[$];
   logic [31:0] mem_model [logic [31:0]];
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   dcache_direct_if #(.WIDTH(32)) bus ();

   dcache_direct #(.WIDTH(32), .LINES(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
      exp_t e;
      e.kind = K_MEM; e.we = we; e.addr = addr; e.data = data; e.strb = strb; e.stalls = 0;
      sbq.push_back(e);
   endtask

   task automatic exp_done(input int kind, input logic [31:0] data, input int stalls);
      exp_t e;
      e.kind = kind; e.we = 1'b0; e.addr = '0; e.data = data; e.strb = '0; e.stalls = stalls;
      sbq.push_back(e);
   endtask

   // memory responder: acks in the ack_lat-th cycle of a request
   initial begin
      int rcnt;
      rcnt = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (man_ack) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hFFFF_0000;
         end else if (rst && bus.mem_req && resp_en) begin
            rcnt++;
            if (rcnt == ack_lat) begin
               bus.mem_ack = 1'b1;
               if (bus.mem_we) begin
                  for (int b = 0; b < 4; b++)
                     if (bus.mem_wstrb[b]) mem_model[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
               end else begin
                  bus.mem_rdata = mem_model[bus.mem_addr];
               end
            end else begin
               bus.mem_ack = 1'b0;
            end
         end else begin
            rcnt = 0;
            bus.mem_ack = 1'b0;
         end
      end
   end

   // monitor
   initial begin
      int   scnt;
      bit   req_seen;
      exp_t e;
      scnt = 0;
      req_seen = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            scnt = 0;
            req_seen = 0;
         end else begin
            if (bus.mem_req && !req_seen) begin
               req_seen = 1;
               if (sbq.size() == 0) begin
                  errors++; checks++;
                  $display("FAIL sb_unexpected_txn: got addr %h, expected none", bus.mem_addr);
               end else begin
                  e = sbq.pop_front();
                  chk("evt_kind_txn", 32'(K_MEM), 32'(e.kind));
                  chk("mem_we", 32'(bus.mem_we), 32'(e.we));
                  chk("mem_addr", bus.mem_addr, e.addr);
                  chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(e.strb));
                  if (e.we) chk("mem_wdata", bus.mem_wdata, e.data);
               end
            end
            if (!bus.mem_req) req_seen = 0;
            if (bus.cpu_re || bus.cpu_we) begin
               if (bus.stall) scnt++;
               else begin
                  if (sbq.size() == 0) begin
                     errors++; checks++;
                     $display("FAIL sb_unexpected_done: got completion, expected none");
                  end else begin
                     e = sbq.pop_front();
                     chk("evt_kind_done", bus.cpu_we ? 32'(K_ST) : 32'(K_LD), 32'(e.kind));
                     if (!bus.cpu_we) chk("cpu_rdata", bus.cpu_rdata, e.data);
                     chk("stall_cycles", 32'(scnt), 32'(e.stalls));
                  end
                  scnt = 0;
               end
            end
         end
      end
   end

   task automatic op(input logic re, input logic we, input logic [2:0] mode,
                     input logic [31:0] addr, input logic [31:0] wdata);
      int n;
      bus.cpu_re = re; bus.cpu_we = we; bus.cpu_mode = mode;
      bus.cpu_addr = addr; bus.cpu_wdata = wdata;
      n = 0;
      @(negedge clk);
      while (bus.stall && n < 60) begin
         n++;
         @(negedge clk);
      end
      if (n >= 60) begin
         errors++; checks++;
         $display("FAIL op_timeout: stall still high after %0d cycles, expected release", n);
      end
      @(posedge clk); #1;
      bus.cpu_re = 1'b0; bus.cpu_we = 1'b0;
   endtask

   task automatic load(input logic [2:0] mode, input logic [31:0] addr);
      op(1'b1, 1'b0, mode, addr, 32'h0);
   endtask

   task automatic store(input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] wdata);
      op(1'b0, 1'b1, mode, addr, wdata);
   endtask

   initial begin
      checks = 0; errors = 0; ack_lat = 3; resp_en = 1; man_ack = 0;
      bus.cpu_re = 0; bus.cpu_we = 0; bus.cpu_mode = 3'b010; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      mem_model[32'h100] = 32'hDEAD_BEEF;
      mem_model[32'h200] = 32'h0;
      mem_model[32'h000] = 32'h1111_1111;
      mem_model[32'h040] = 32'h2222_2222;
      mem_model[32'h104] = 32'h8000_0001;
      mem_model[32'h300] = 32'h0BAD_F00D;
      mem_model[32'h304] = 32'h0000_0304;
      mem_model[32'h308] = 32'h0000_0308;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // cold miss then extraction hits
      exp_mem(1'b0, 32'h100, 32'h0, 4'b0000); exp_done(K_LD, 32'hDEAD_BEEF, 4);
      load(3'b010, 32'h100);
      exp_done(K_LD, 32'hFFFF_FFDE, 0); load(3'b000, 32'h103);
      exp_done(K_LD, 32'h0000_00DE, 0); load(3'b100, 32'h103);
      exp_done(K_LD, 32'hFFFF_DEAD, 0); load(3'b001, 32'h102);
      exp_done(K_LD, 32'h0000_BEEF, 0); load(3'b101, 32'h100);
      exp_done(K_LD, 32'hFFFF_BEEF, 0); load(3'b001, 32'h101);

      // store hits merge into the line
      exp_mem(1'b1, 32'h100, 32'h5555_5555, 4'b0010); exp_done(K_ST, 32'h0, 4);
      store(3'b000, 32'h101, 32'hAABB_CC55);
      exp_done(K_LD, 32'hDEAD_55EF, 0); load(3'b010, 32'h100);
      exp_mem(1'b1, 32'h100, 32'h1234_1234, 4'b1100); exp_done(K_ST, 32'h0, 4);
      store(3'b001, 32'h102, 32'h0000_1234);
      exp_done(K_LD, 32'h1234_55EF, 0); load(3'b010, 32'h100);

      // store miss does not allocate
      exp_mem(1'b1, 32'h200, 32'hCAFE_F00D, 4'b1111); exp_done(K_ST, 32'h0, 4);
      store(3'b010, 32'h200, 32'hCAFE_F00D);
      exp_mem(1'b0, 32'h200, 32'h0, 4'b0000); exp_done(K_LD, 32'hCAFE_F00D, 4);
      load(3'b010, 32'h200);

      // conflict eviction on index 0
      exp_mem(1'b0, 32'h000, 32'h0, 4'b0000); exp_done(K_LD, 32'h1111_1111, 4);
      load(3'b010, 32'h000);
      exp_mem(1'b0, 32'h040, 32'h0, 4'b0000); exp_done(K_LD, 32'h2222_2222, 4);
      load(3'b010, 32'h040);
      exp_mem(1'b0, 32'h000, 32'h0, 4'b0000); exp_done(K_LD, 32'h1111_1111, 4);
      load(3'b010, 32'h000);

      // stray ack in IDLE is ignored
      man_ack = 1; @(posedge clk); #1; man_ack = 0;
      @(posedge clk); #1;
      exp_done(K_LD, 32'h1111_1111, 0); load(3'b010, 32'h000);

      // single-cycle ack latency
      ack_lat = 1;
      exp_mem(1'b0, 32'h104, 32'h0, 4'b0000); exp_done(K_LD, 32'hFFFF_8000, 2);
      load(3'b001, 32'h106);
      ack_lat = 2;

      // reset abandons an in-flight fill
      resp_en = 0;
      exp_mem(1'b0, 32'h300, 32'h0, 4'b0000);
      bus.cpu_re = 1'b1; bus.cpu_we = 1'b0; bus.cpu_mode = 3'b010; bus.cpu_addr = 32'h300;
      repeat (3) @(posedge clk);
      #1;
      bus.cpu_re = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk("abort_stall_in_rst", 32'(bus.stall), 32'd0);
      @(posedge clk); #1;
      chk("abort_mem_req", 32'(bus.mem_req), 32'd0);
      rst = 1'b1;
      man_ack = 1; @(posedge clk); #1; man_ack = 0;
      chk("abort_late_ack_req", 32'(bus.mem_req), 32'd0);
      chk("abort_late_ack_stall", 32'(bus.stall), 32'd0);
`ifdef DCACHE_STATS_EN
      chk("stats_hit_cleared", hit_count, 32'd0);
      chk("stats_miss_cleared", miss_count, 32'd0);
`endif
      resp_en = 1;
      exp_mem(1'b0, 32'h300, 32'h0, 4'b0000); exp_done(K_LD, 32'h0BAD_F00D, 3);
      load(3'b010, 32'h300);
      exp_done(K_LD, 32'h0BAD_F00D, 0); load(3'b010, 32'h300);
      exp_mem(1'b0, 32'h304, 32'h0, 4'b0000); exp_done(K_LD, 32'h0000_0304, 3);
      load(3'b010, 32'h304);
      exp_mem(1'b0, 32'h308, 32'h0, 4'b0000); exp_done(K_LD, 32'h0000_0308, 3);
      load(3'b010, 32'h308);
      exp_done(K_LD, 32'h0000_0304, 0); load(3'b010, 32'h304);
`ifdef DCACHE_STATS_EN
      chk("stats_hit_count", hit_count, 32'd2);
      chk("stats_miss_count", miss_count, 32'd3);
`endif

      repeat (3) @(posedge clk);
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
